// File: rtl/hpi_pkg.sv
// hpi_pkg: shared states, HPI register indices and transfer direction for the HPI sequencer
package hpi_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_RECOVER
    } state_t;

    localparam logic [1:0] HPI_DATA    = 2'd0;
    localparam logic [1:0] HPI_MAILBOX = 2'd1;
    localparam logic [1:0] HPI_ADDRESS = 2'd2;
    localparam logic [1:0] HPI_STATUS  = 2'd3;

    localparam logic DIR_READ  = 1'b0;
    localparam logic DIR_WRITE = 1'b1;
endpackage

// File: rtl/hpi_bus_sequencer.sv
// hpi_bus_sequencer: turns one Avalon-MM access into one timed CY7C67200 HPI bus cycle
module hpi_bus_sequencer
    import hpi_pkg::*;
#(
    parameter int SETUP_CYC    = 1,
    parameter int STROBE_CYC   = 2,
    parameter int HOLD_CYC     = 1,
    parameter int RECOVERY_CYC = 2,
    parameter int CNT_W        = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [15:0] avs_writedata,
    output logic [15:0] avs_readdata,
    output logic        avs_waitrequest,
    output logic        otg_cs_n,
    output logic        otg_rd_n,
    output logic        otg_wr_n,
    output logic [1:0]  otg_addr,
    output logic [15:0] otg_data_out,
    output logic        otg_data_oe,
    input  logic [15:0] otg_data_in
);
    localparam logic [CNT_W-1:0] SETUP_LD   = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LD  = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD    = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] RECOVER_LD = CNT_W'(RECOVERY_CYC - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic [1:0]       addr_q, addr_d;
    logic [15:0]      wdata_q, wdata_d, rdata_q, rdata_d;
    logic             cs_n_q, cs_n_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d, oe_q, oe_d;
    logic             last, busy_d;

    always_comb begin
        last    = cnt_q == '0;
        state_d = state_q;
        cnt_d   = last ? '0 : cnt_q - CNT_W'(1);
        dir_d   = dir_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: if (avs_read || avs_write) begin
                state_d = ST_SETUP;
                cnt_d   = SETUP_LD;
                dir_d   = avs_write ? DIR_WRITE : DIR_READ;
                addr_d  = avs_address;
                wdata_d = avs_writedata;
            end
            ST_SETUP: if (last) begin
                state_d = ST_STROBE;
                cnt_d   = STROBE_LD;
            end
            ST_STROBE: if (last) begin
                state_d = ST_HOLD;
                cnt_d   = HOLD_LD;
                rdata_d = dir_q == DIR_READ ? otg_data_in : rdata_q;
            end
            ST_HOLD: if (last) begin
                state_d = ST_RECOVER;
                cnt_d   = RECOVER_LD;
            end
            ST_RECOVER: if (last) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // pins are decoded from the next state so every HPI output comes straight from a flop
        busy_d = state_d inside {ST_SETUP, ST_STROBE, ST_HOLD};
        cs_n_d = ~busy_d;
        rd_n_d = ~(state_d == ST_STROBE && dir_d == DIR_READ);
        wr_n_d = ~(state_d == ST_STROBE && dir_d == DIR_WRITE);
        oe_d   = busy_d && dir_d == DIR_WRITE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dir_q   <= DIR_READ;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cs_n_q  <= 1'b1;
            rd_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cs_n_q  <= cs_n_d;
            rd_n_q  <= rd_n_d;
            wr_n_q  <= wr_n_d;
            oe_q    <= oe_d;
        end
    end

    assign avs_waitrequest = (avs_read | avs_write) & ~(state_q == ST_HOLD && last);
    assign avs_readdata    = rdata_q;
    assign otg_cs_n        = cs_n_q;
    assign otg_rd_n        = rd_n_q;
    assign otg_wr_n        = wr_n_q;
    assign otg_addr        = addr_q;
    assign otg_data_out    = wdata_q;
    assign otg_data_oe     = oe_q;
endmodule

// File: tb/tb_hpi_bus_sequencer.sv
// tb_hpi_bus_sequencer: phase-window reference model checked cycle by cycle on two parameter sets
module tb_hpi_bus_sequencer;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  avs_address = '0;
    logic        avs_read = 1'b0, avs_write = 1'b0;
    logic [15:0] avs_writedata = '0, otg_data_in = '0;

    logic [15:0] rd_a, rd_b, dout_a, dout_b;
    logic [1:0]  addr_a, addr_b;
    logic        wait_a, wait_b, cs_a, cs_b, rdn_a, rdn_b, wrn_a, wrn_b, oe_a, oe_b;

    logic [15:0] o_rdata, o_dout;
    logic [1:0]  o_addr;
    logic        o_wait, o_cs, o_rdn, o_wrn, o_oe;

    int          checks = 0, errors = 0, cyc = 0, sel = 0;
    int          fall_prev = 0, fall_last = 0;
    int          S = 1, T = 2, H = 1, R = 2;
    logic [15:0] exp_rdata = '0;

    hpi_bus_sequencer dut_a (
        .clk(clk), .reset_n(reset_n), .avs_address(avs_address), .avs_read(avs_read),
        .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_readdata(rd_a),
        .avs_waitrequest(wait_a), .otg_cs_n(cs_a), .otg_rd_n(rdn_a), .otg_wr_n(wrn_a),
        .otg_addr(addr_a), .otg_data_out(dout_a), .otg_data_oe(oe_a), .otg_data_in(otg_data_in)
    );

    hpi_bus_sequencer #(.SETUP_CYC(2), .STROBE_CYC(3), .HOLD_CYC(2), .RECOVERY_CYC(1), .CNT_W(4)) dut_b (
        .clk(clk), .reset_n(reset_n), .avs_address(avs_address), .avs_read(avs_read),
        .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_readdata(rd_b),
        .avs_waitrequest(wait_b), .otg_cs_n(cs_b), .otg_rd_n(rdn_b), .otg_wr_n(wrn_b),
        .otg_addr(addr_b), .otg_data_out(dout_b), .otg_data_oe(oe_b), .otg_data_in(otg_data_in)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        o_rdata = sel != 0 ? rd_b   : rd_a;
        o_dout  = sel != 0 ? dout_b : dout_a;
        o_addr  = sel != 0 ? addr_b : addr_a;
        o_wait  = sel != 0 ? wait_b : wait_a;
        o_cs    = sel != 0 ? cs_b   : cs_a;
        o_rdn   = sel != 0 ? rdn_b  : rdn_a;
        o_wrn   = sel != 0 ? wrn_b  : wrn_a;
        o_oe    = sel != 0 ? oe_b   : oe_a;
    end

    function automatic void chk(string tag, logic [15:0] obs, logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            avs_read = 1'b0; avs_write = 1'b0;
            avs_address = 2'($urandom); avs_writedata = 16'($urandom); otg_data_in = 16'($urandom);
            @(negedge clk);
            chk("idle_cs_n", 16'(o_cs), 16'd1);
            chk("idle_rd_n", 16'(o_rdn), 16'd1);
            chk("idle_wr_n", 16'(o_wrn), 16'd1);
            chk("idle_oe", 16'(o_oe), 16'd0);
            chk("idle_wait", 16'(o_wait), 16'd0);
            chk("idle_rdata", o_rdata, exp_rdata);
        end
    endtask

    // Cycle k=0 is the request cycle seen in IDLE; the cycle then walks SETUP, STROBE, HOLD, RECOVER windows.
    task automatic run_txn(input logic rd, input logic wr, input logic [1:0] a, input logic [15:0] d,
                           input logic [15:0] pad, input logic nrd, input logic nwr,
                           input logic [1:0] na, input logic [15:0] nd);
        int   done_k;
        logic w, r, busy, strobe;
        w = wr;
        r = rd & ~wr;
        done_k = S + T + H;
        for (int k = 0; k <= done_k + R; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                avs_read = rd; avs_write = wr; avs_address = a; avs_writedata = d;
            end else if (k <= done_k) begin
                avs_address = 2'($urandom); avs_writedata = 16'($urandom);
            end else begin
                avs_read = nrd; avs_write = nwr; avs_address = na; avs_writedata = nd;
            end
            otg_data_in = (k == S + T) ? pad : 16'($urandom);
            @(negedge clk);
            busy   = k >= 1 && k <= done_k;
            strobe = k > S && k <= S + T;
            if (k == S + T + 1 && r) exp_rdata = pad;
            if (k == 1) begin fall_prev = fall_last; fall_last = cyc; end
            chk("cs_n", 16'(o_cs), 16'(!busy));
            chk("rd_n", 16'(o_rdn), 16'(!(strobe && r)));
            chk("wr_n", 16'(o_wrn), 16'(!(strobe && w)));
            chk("oe", 16'(o_oe), 16'(busy && w));
            chk("rdata", o_rdata, exp_rdata);
            chk("wait", 16'(o_wait), k <= done_k ? 16'(k != done_k) : 16'(nrd | nwr));
            if (busy) chk("addr", 16'(o_addr), 16'(a));
            if (busy && w) chk("dout", o_dout, d);
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        reset_n = 1'b0;
        avs_read = 1'b0; avs_write = 1'b0;
        exp_rdata = '0;
        #1;
        chk("rst_cs_n", 16'(o_cs), 16'd1);
        chk("rst_rd_n", 16'(o_rdn), 16'd1);
        chk("rst_wr_n", 16'(o_wrn), 16'd1);
        chk("rst_oe", 16'(o_oe), 16'd0);
        chk("rst_addr", 16'(o_addr), 16'd0);
        chk("rst_dout", o_dout, 16'd0);
        chk("rst_rdata", o_rdata, 16'd0);
        #2 reset_n = 1'b1;
    endtask

    initial begin
        logic [15:0] d, p;
        logic [1:0]  a;
        logic        w;
        repeat (2) @(posedge clk);
        pulse_reset();
        idle(2);
        run_txn(1'b0, 1'b1, 2'd2, 16'h1234, 16'h0, 1'b0, 1'b0, 2'd0, 16'h0);
        run_txn(1'b1, 1'b0, 2'd0, 16'h0, 16'hBEEF, 1'b0, 1'b0, 2'd0, 16'h0);
        idle(1);
        d = 16'($urandom); a = 2'($urandom); p = 16'($urandom);
        run_txn(1'b0, 1'b1, 2'd3, d, 16'h0, 1'b1, 1'b0, a, 16'h0);
        run_txn(1'b1, 1'b0, a, 16'h0, p, 1'b0, 1'b0, 2'd0, 16'h0);
        chk("cs_spacing", 16'(fall_last - fall_prev), 16'd7);
        run_txn(1'b1, 1'b1, 2'd1, 16'h00A5, 16'h7777, 1'b0, 1'b0, 2'd0, 16'h0);
        for (int i = 0; i < 6; i++) begin
            w = 1'($urandom);
            run_txn(!w, w, 2'($urandom), 16'($urandom), 16'($urandom), 1'b0, 1'b0, 2'd0, 16'h0);
            idle(int'($urandom_range(0, 2)));
        end
        @(posedge clk); #1;
        avs_write = 1'b1; avs_address = 2'd3; avs_writedata = 16'h5A5A;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("strobe_before_rst", 16'(o_wrn), 16'd0);
        reset_n = 1'b0;
        avs_write = 1'b0;
        exp_rdata = '0;
        #1;
        chk("midrst_cs_n", 16'(o_cs), 16'd1);
        chk("midrst_wr_n", 16'(o_wrn), 16'd1);
        chk("midrst_oe", 16'(o_oe), 16'd0);
        chk("midrst_rdata", o_rdata, 16'd0);
        #2 reset_n = 1'b1;
        idle(1);
        run_txn(1'b0, 1'b1, 2'd1, 16'hC0DE, 16'h0, 1'b0, 1'b0, 2'd0, 16'h0);
        sel = 1; S = 2; T = 3; H = 2; R = 1;
        pulse_reset();
        idle(2);
        run_txn(1'b1, 1'b0, 2'd0, 16'h0, 16'($urandom), 1'b0, 1'b0, 2'd0, 16'h0);
        run_txn(1'b0, 1'b1, 2'd2, 16'($urandom), 16'h0, 1'b0, 1'b0, 2'd0, 16'h0);
        run_txn(1'b1, 1'b0, 2'd3, 16'h0, 16'($urandom), 1'b0, 1'b0, 2'd0, 16'h0);
        idle(1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
